// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory address/data plus the decode valid/ready handshake.
// The fetch unit connects through 'master'; memory and decode models connect through 'slave'.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_in;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_inst;
    logic [ADDR_W-1:0] if_pc;

    modport master (
        output inst_addr,
        input  inst_in,
        output if_valid,
        input  if_ready,
        output if_inst,
        output if_pc
    );

    modport slave (
        input  inst_addr,
        output inst_in,
        input  if_valid,
        output if_ready,
        input  if_inst,
        input  if_pc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational instruction memory and buffers
// {PC+4, instruction} pairs in a small FIFO for decode; a taken branch flushes and redirects.
module inst_fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_unit_if.master   bus,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_addr,
    output logic                fetch_stall
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_r, pc_nxt_s, pc_inc_s;
    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_r, rd_ptr_nxt_s;
    logic [DATA_W-1:0] inst_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
    logic              valid_s, pop_s, push_s;

    // Handshake decode: a full FIFO still accepts a push when the head leaves this cycle.
    always_comb begin
        valid_s  = (count_r != '0);
        pop_s    = valid_s & bus.if_ready;
        push_s   = !branch_taken & ((count_r < DEPTH_C) | pop_s);
        pc_inc_s = pc_r + PC_STEP;
    end

    // Next-state for PC, pointers and occupancy; a branch discards everything, including a popping head.
    always_comb begin
        pc_nxt_s     = pc_r;
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (branch_taken) begin
            pc_nxt_s     = branch_addr & ALIGN_MASK;
            count_nxt_s  = '0;
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
        end else begin
            if (push_s) begin
                pc_nxt_s     = pc_inc_s;
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                pc_nxt_s     = pc_r;
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control state register with synchronous reset taking priority over branch/push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            count_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            pc_r     <= pc_nxt_s;
            count_r  <= count_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
        end
    end

    // FIFO storage: each entry holds the fetched word and the address following it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_r[i] <= '0;
                pc_mem_r[i]   <= '0;
            end
        end else if (push_s) begin
            inst_mem_r[wr_ptr_r] <= bus.inst_in;
            pc_mem_r[wr_ptr_r]   <= pc_inc_s;
        end
    end

    // Head presentation from registered storage; empty FIFO shows zeros.
    always_comb begin
        bus.inst_addr = pc_r;
        bus.if_valid  = valid_s;
        if (valid_s) begin
            bus.if_inst = inst_mem_r[rd_ptr_r];
            bus.if_pc   = pc_mem_r[rd_ptr_r];
        end else begin
            bus.if_inst = '0;
            bus.if_pc   = '0;
        end
        fetch_stall = (count_r == DEPTH_C) & !pop_s & !branch_taken;
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized traffic checked against a
// queue-based reference model; a second instance with a high reset PC exercises wrap-around.
module tb_inst_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst, branch_taken, fetch_stall;
    logic [31:0] branch_addr;
    logic        rst2, branch_taken2, fetch_stall2;
    logic [31:0] branch_addr2;

    inst_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    inst_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 | {2'b00, a[31:2]};
    endfunction

    assign bus_a.inst_in = mem_word(bus_a.inst_addr);
    assign bus_b.inst_in = mem_word(bus_b.inst_addr);

    inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_a),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .fetch_stall  (fetch_stall)
    );

    inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk          (clk),
        .rst          (rst2),
        .bus          (bus_b),
        .branch_taken (branch_taken2),
        .branch_addr  (branch_addr2),
        .fetch_stall  (fetch_stall2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [63:0] m_q [$];
    bit          m_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: FIFO is a queue of {pc+4, inst}; outputs derived from queue size and head.
    task automatic model_check(input logic b, input logic rdy);
        logic [31:0] h_pc, h_inst;
        int          n;
        logic        stall_e;
        n = m_q.size();
        if (n > 0) {h_pc, h_inst} = m_q[0];
        else begin
            h_pc   = 32'h0;
            h_inst = 32'h0;
        end
        stall_e = (n == DEPTH) && !(rdy && n > 0) && !b;
        chk("model_inst_addr", bus_a.inst_addr, m_pc);
        chk("model_if_valid", {31'b0, bus_a.if_valid}, {31'b0, n > 0});
        chk("model_if_inst", bus_a.if_inst, h_inst);
        chk("model_if_pc", bus_a.if_pc, h_pc);
        chk("model_fetch_stall", {31'b0, fetch_stall}, {31'b0, stall_e});
    endtask

    task automatic model_update(input logic r, input logic b, input logic [31:0] ba, input logic rdy);
        int n;
        bit pop_m;
        n = m_q.size();
        if (r) begin
            m_pc = 32'h0000_0000;
            m_q.delete();
            m_known = 1'b1;
        end else if (b) begin
            m_q.delete();
            m_pc = ba & 32'hFFFF_FFFC;
        end else begin
            pop_m = (n > 0) && rdy;
            if (pop_m) void'(m_q.pop_front());
            if (n < DEPTH || pop_m) begin
                m_q.push_back({m_pc + 32'd4, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock: drive at negedge, check pre-edge state, advance model, settle 1 after posedge.
    task automatic cycle(input logic r, input logic b, input logic [31:0] ba, input logic rdy);
        @(negedge clk);
        rst          = r;
        branch_taken = b;
        branch_addr  = ba;
        bus_a.if_ready = rdy;
        #1;
        if (m_known) model_check(b, rdy);
        @(posedge clk);
        model_update(r, b, ba, rdy);
        #1;
    endtask

    initial begin
        rst = 1'b1; branch_taken = 1'b0; branch_addr = 32'h0; bus_a.if_ready = 1'b0;
        rst2 = 1'b1; branch_taken2 = 1'b0; branch_addr2 = 32'h0; bus_b.if_ready = 1'b1;

        // Streaming with decode always ready
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("reset_valid", {31'b0, bus_a.if_valid}, 32'd0);
        chk("reset_inst", bus_a.if_inst, 32'h0);
        chk("reset_pc", bus_a.if_pc, 32'h0);
        chk("reset_addr", bus_a.inst_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_c1_valid", {31'b0, bus_a.if_valid}, 32'd1);
        chk("t1_c1_inst", bus_a.if_inst, 32'hA000_0000);
        chk("t1_c1_pc", bus_a.if_pc, 32'h4);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_c2_inst", bus_a.if_inst, 32'hA000_0001);
        chk("t1_c2_pc", bus_a.if_pc, 32'h8);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_c6_inst", bus_a.if_inst, 32'hA000_0005);

        // Back-pressure fills the FIFO and stalls the PC
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_stall", {31'b0, fetch_stall}, 32'd1);
        chk("t2_addr", bus_a.inst_addr, 32'h8);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_addr_hold", bus_a.inst_addr, 32'h8);
        chk("t2_head_hold", bus_a.if_inst, 32'hA000_0000);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t2_pop1_inst", bus_a.if_inst, 32'hA000_0001);
        chk("t3_addr_adv", bus_a.inst_addr, 32'hC);
        chk("t3_no_stall", {31'b0, fetch_stall}, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t2_pop2_inst", bus_a.if_inst, 32'hA000_0002);
        chk("t2_pop2_valid", {31'b0, bus_a.if_valid}, 32'd1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_still_full", {31'b0, fetch_stall}, 32'd1);

        // Branch while full, then reset racing a branch
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        chk("t4_flush_valid", {31'b0, bus_a.if_valid}, 32'd0);
        chk("t4_target_addr", bus_a.inst_addr, 32'h100);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t4_target_inst", bus_a.if_inst, 32'hA000_0040);
        chk("t4_target_pc", bus_a.if_pc, 32'h104);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        chk("t5_addr", bus_a.inst_addr, 32'h0);
        chk("t5_valid", {31'b0, bus_a.if_valid}, 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                  $urandom, $urandom_range(0, 3) != 0);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap-around from a high reset vector
        @(negedge clk); rst2 = 1'b1;
        @(posedge clk); #1;
        chk("t6_reset_addr", bus_b.inst_addr, 32'hFFFF_FFF8);
        @(negedge clk); rst2 = 1'b0;
        @(posedge clk); #1;
        chk("t6_pc0", bus_b.if_pc, 32'hFFFF_FFFC);
        chk("t6_valid0", {31'b0, bus_b.if_valid}, 32'd1);
        @(posedge clk); #1;
        chk("t6_pc1", bus_b.if_pc, 32'h0000_0000);
        chk("t6_addr1", bus_b.inst_addr, 32'h0000_0000);
        @(posedge clk); #1;
        chk("t6_pc2", bus_b.if_pc, 32'h0000_0004);
        chk("t6_stall", {31'b0, fetch_stall2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch-side initiator for the instruction memory. It owns the PC, drives the word address into the memory and captures the returned instruction.
- The memory read is combinational: the instruction is valid in the same cycle as the address.
- Fetched instructions are buffered in a small FIFO and handed to the decode stage over a valid/ready handshake.
- Handles taken branches by flushing the FIFO and redirecting the PC.

Parameters:
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width.
- DEPTH, 2, fetch FIFO entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, PC value after reset (must be word aligned).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- inst_addr  out  ADDR_W  byte address to instruction memory; always equals PC, bits[1:0]=00
- inst_in  in  DATA_W  instruction returned by memory for inst_addr, same cycle
- branch_taken  in  1  redirect request from execute stage
- branch_addr  in  ADDR_W  redirect target; bits[1:0] ignored (forced 00)
- if_valid  out  1  FIFO head holds a valid instruction
- if_ready  in  1  decode stage accepts head this cycle
- if_inst  out  DATA_W  head instruction
- if_pc  out  ADDR_W  head PC+4 (address of fetched instruction + 4)
- fetch_stall  out  1  fetch blocked this cycle (FIFO full, no pop)

Behaviour:
- Reset (rst=1 at posedge): PC<=RESET_PC, FIFO count<=0, rd/wr pointers<=0.
  - Overrides branch_taken, push and pop in the same cycle.
  - After reset: if_valid=0, if_inst=0, if_pc=0, fetch_stall=0, inst_addr=RESET_PC.
- inst_addr is driven directly from the PC register (no combinational path from inputs).
- pop = if_valid & if_ready.
- push = !branch_taken & (count<DEPTH | pop).
- On push:
  - write {PC+4, inst_in} at wr pointer;
  - PC<=PC+4 (modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0);
  - wr pointer increments modulo DEPTH.
- No push: PC holds.
- Pop: rd pointer increments modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: push still happens, count stays DEPTH (no bubble).
- Empty: if_valid=0, if_inst=0, if_pc=0. if_ready is ignored and no pop occurs.
- branch_taken=1 (highest priority after rst):
  - count<=0 and pointers<=0; all buffered entries are discarded, including a head being popped this cycle;
  - PC<={branch_addr[ADDR_W-1:2],2'b00};
  - no push this cycle.
  - Next cycle: inst_addr=target and if_valid=0. The target instruction appears at the head the cycle after.
- Branch while FIFO empty or full: same flush behaviour.
- Consecutive branch cycles: the last target wins, and nothing is pushed until branch_taken falls.
- Latency: an instruction is visible at the head one cycle after its address was presented, provided it is pushed that cycle.
- fetch_stall = (count==DEPTH) & !pop & !branch_taken.
- Head outputs are registered FIFO storage muxed by the rd pointer. There is no combinational path from inst_in to if_inst.

Test Plan:
1. Bench memory returns inst=32'hA000_0000|addr[31:2]. Release rst with if_ready=1.
   - Cycle 1: if_valid=1, if_inst=A000_0000, if_pc=4.
   - Cycle 2: if_inst=A000_0001, if_pc=8.
   - Continuous, one instruction per cycle.
2. Hold if_ready=0 from reset.
   - After 2 cycles count=2 and fetch_stall=1.
   - inst_addr stays 8 and PC does not advance.
   - Raise if_ready: pops A000_0000, then A000_0001, then A000_0002 with no bubble.
3. FIFO full, if_ready=1 in the same cycle as push: count stays 2, PC advances by 4, fetch_stall=0.
4. branch_taken=1 with branch_addr=32'h0000_0103 while FIFO is full.
   - Next cycle: if_valid=0, inst_addr=0x100.
   - Following cycle: if_inst=A000_0040, if_pc=0x104.
5. Reset mid-stream (count=1, branch_taken=1 in the same cycle): next cycle PC=RESET_PC, if_valid=0, and the branch is ignored.
6. RESET_PC=32'hFFFF_FFF8 with if_ready=1: heads in order are if_pc=FFFF_FFFC, 0, 4, confirming PC wrap-around.
